// File: rtl/serial_cmp_pkg.sv
// ---------------------------------------------------------------------------
// serial_cmp_pkg
// Shared definitions for the serial magnitude comparator sequencer:
//   - state encodings for the IDLE/RUN/DONE sequencer
//   - cascade register initial values {g, e, l} = {0, 1, 0}, which means
//     "equal so far" before any nibble has been examined
//   - a one-hot check on a g/e/l triple
// ---------------------------------------------------------------------------
package serial_cmp_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE_ENC,
        RUN  = ST_RUN_ENC,
        DONE = ST_DONE_ENC
    } state_e;

    localparam logic CASC_G_INIT = 1'b0;
    localparam logic CASC_E_INIT = 1'b1;
    localparam logic CASC_L_INIT = 1'b0;

    // True when exactly one of g/e/l is set.
    function automatic logic gel_onehot(input logic g, input logic e, input logic l);
        gel_onehot = ({g, e, l} == 3'b100) || ({g, e, l} == 3'b010) || ({g, e, l} == 3'b001);
    endfunction

endpackage

// File: rtl/four_bit_comparator.sv
// ---------------------------------------------------------------------------
// four_bit_comparator
// Combinational cascadable 4-bit unsigned magnitude comparator slice.
// An unequal nibble decides the result on its own; an equal nibble passes
// the incoming cascade (result of the less significant part) through.
// Ports:
//   a, b                 4-bit operands
//   g_in, e_in, l_in     cascade from less significant nibbles
//   g_out, e_out, l_out  combined result
// ---------------------------------------------------------------------------
module four_bit_comparator (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       g_in,
    input  logic       e_in,
    input  logic       l_in,
    output logic       g_out,
    output logic       e_out,
    output logic       l_out
);

    // Local nibble decides if unequal, otherwise the cascade passes through.
    always_comb begin
        g_out = 1'b0;
        e_out = 1'b0;
        l_out = 1'b0;
        if (a > b) begin
            g_out = 1'b1;
        end else if (a < b) begin
            l_out = 1'b1;
        end else begin
            g_out = g_in;
            e_out = e_in;
            l_out = l_in;
        end
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// serial_magnitude_comparator_ctrl
// Compares two 4*NIBBLES-bit operands with a single four_bit_comparator
// slice, one nibble per clock, LSB nibble first. Each nibble's g/e/l result
// is registered and fed back as the cascade for the next nibble.
//
// Timing: start accepted in cycle T -> busy on T+1..T+NIBBLES -> done pulse
// with gt/eq/lt valid in T+NIBBLES+1. gt/eq/lt hold until the next accepted
// start. A start in the DONE cycle is accepted (back-to-back compares).
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   start            compare request, ignored while busy
//   a, b             operands, latched on accepted start
//   busy             compare in progress
//   done             one-cycle result-valid pulse
//   gt, eq, lt       A>B, A==B, A<B
//
// Build option: SERIAL_CMP_SIGNED_EN treats operands as two's complement by
// inverting the sign bit of both latched operands (offset binary) before the
// MSB nibble reaches the slice. Undefined: plain unsigned compare.
// ---------------------------------------------------------------------------
module serial_magnitude_comparator_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic                 gt,
    output logic                 eq,
    output logic                 lt
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_lat_q, a_lat_d;
    logic [W-1:0]    b_lat_q, b_lat_d;
    logic            casc_g_q, casc_g_d;
    logic            casc_e_q, casc_e_d;
    logic            casc_l_q, casc_l_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            gt_q, gt_d;
    logic            eq_q, eq_d;
    logic            lt_q, lt_d;

    logic [W-1:0]    a_eff_s;
    logic [W-1:0]    b_eff_s;
    logic [CW+1:0]   nib_base_s;
    logic [3:0]      a_nib_s;
    logic [3:0]      b_nib_s;
    logic            slice_g_s;
    logic            slice_e_s;
    logic            slice_l_s;

`ifdef SERIAL_CMP_SIGNED_EN
    // Flipping the sign bit maps two's complement onto offset binary, so the
    // unsigned slice then orders the values by their signed meaning. Only the
    // MSB nibble is affected because the mask covers the top bit alone.
    localparam logic [W-1:0] SIGN_MASK = {1'b1, {(W-1){1'b0}}};
    assign a_eff_s = a_lat_q ^ SIGN_MASK;
    assign b_eff_s = b_lat_q ^ SIGN_MASK;
`else
    assign a_eff_s = a_lat_q;
    assign b_eff_s = b_lat_q;
`endif

    // Counter k selects bits [4k+3:4k]; the counter never exceeds NIBBLES-1.
    assign nib_base_s = {cnt_q, 2'b00};
    assign a_nib_s    = a_eff_s[nib_base_s +: 4];
    assign b_nib_s    = b_eff_s[nib_base_s +: 4];

    four_bit_comparator u_slice (
        .a     (a_nib_s),
        .b     (b_nib_s),
        .g_in  (casc_g_q),
        .e_in  (casc_e_q),
        .l_in  (casc_l_q),
        .g_out (slice_g_s),
        .e_out (slice_e_s),
        .l_out (slice_l_s)
    );

    // Next-state and registered-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_lat_d  = a_lat_q;
        b_lat_d  = b_lat_q;
        casc_g_d = casc_g_q;
        casc_e_d = casc_e_q;
        casc_l_d = casc_l_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        gt_d     = gt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;

        case (state_q)
            IDLE, DONE: begin
                // DONE behaves like IDLE for start acceptance so compares can
                // run back to back without a dead cycle.
                if (start) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    a_lat_d  = a;
                    b_lat_d  = b;
                    casc_g_d = CASC_G_INIT;
                    casc_e_d = CASC_E_INIT;
                    casc_l_d = CASC_L_INIT;
                    gt_d     = 1'b0;
                    eq_d     = 1'b0;
                    lt_d     = 1'b0;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                casc_g_d = slice_g_s;
                casc_e_d = slice_e_s;
                casc_l_d = slice_l_s;
                if (cnt_q == LAST_NIB) begin
                    // The result of the MSB nibble is the final answer; load
                    // the outputs now so they appear with the done pulse.
                    state_d = DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    gt_d    = slice_g_s;
                    eq_d    = slice_e_s;
                    lt_d    = slice_l_s;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_lat_q  <= '0;
            b_lat_q  <= '0;
            casc_g_q <= CASC_G_INIT;
            casc_e_q <= CASC_E_INIT;
            casc_l_q <= CASC_L_INIT;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_lat_q  <= a_lat_d;
            b_lat_q  <= b_lat_d;
            casc_g_q <= casc_g_d;
            casc_e_q <= casc_e_d;
            casc_l_q <= casc_l_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_magnitude_comparator_ctrl
// Two instances: NIBBLES=4 for directed timing/control tests and NIBBLES=1
// for an exhaustive 4-bit sweep. Expected {gt,eq,lt} is pushed to a
// per-instance queue on each accepted start and popped on each done pulse.
// ---------------------------------------------------------------------------
module tb_serial_magnitude_comparator_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start1;
    logic [15:0] a4, b4;
    logic [3:0]  a1, b1;
    logic        busy4, done4, gt4, eq4, lt4;
    logic        busy1, done1, gt1, eq1, lt1;

    int          n_vec = 0;
    int          n_err = 0;
    int          done4_cnt = 0;
    logic [2:0]  q4[$];
    logic [2:0]  q1[$];

    always #5 clk = ~clk;

    serial_magnitude_comparator_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .gt(gt4), .eq(eq4), .lt(lt4)
    );

    serial_magnitude_comparator_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp16(input logic [15:0] a, input logic [15:0] b);
`ifdef SERIAL_CMP_SIGNED_EN
        if ($signed(a) > $signed(b)) return 3'b100;
        else if ($signed(a) < $signed(b)) return 3'b001;
        else return 3'b010;
`else
        if (a > b) return 3'b100;
        else if (a < b) return 3'b001;
        else return 3'b010;
`endif
    endfunction

    function automatic logic [2:0] exp4(input logic [3:0] a, input logic [3:0] b);
`ifdef SERIAL_CMP_SIGNED_EN
        if ($signed(a) > $signed(b)) return 3'b100;
        else if ($signed(a) < $signed(b)) return 3'b001;
        else return 3'b010;
`else
        if (a > b) return 3'b100;
        else if (a < b) return 3'b001;
        else return 3'b010;
`endif
    endfunction

    // Scoreboard for the 4-nibble instance.
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            done4_cnt++;
            if (q4.size() == 0) begin
                check_val("dut4_unexpected_done", 32'd1, 32'd0);
            end else begin
                check_val("dut4_result", {29'd0, gt4, eq4, lt4}, {29'd0, q4.pop_front()});
            end
        end
    end

    // Scoreboard for the 1-nibble instance.
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check_val("dut1_unexpected_done", 32'd1, 32'd0);
            end else begin
                check_val("dut1_result", {29'd0, gt1, eq1, lt1}, {29'd0, q1.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full compare on dut4 with cycle-exact busy/done checks.
    task automatic run4(input logic [15:0] a, input logic [15:0] b);
        logic [2:0] e;
        e      = exp16(a, b);
        a4     = a;
        b4     = b;
        start4 = 1'b1;
        q4.push_back(e);
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("run4_busy", {30'd0, busy4, done4}, 32'd2);
            a4 = ~a4;
            tick();
        end
        check_val("run4_done", {30'd0, busy4, done4}, 32'd1);
        tick();
        check_val("run4_hold", {28'd0, done4, gt4, eq4, lt4}, {28'd0, 1'b0, e});
    endtask

    initial begin
        logic [2:0] e_a, e_b;
        int         base_cnt;
        rst = 1'b1; start4 = 1'b0; start1 = 1'b0;
        a4 = '0; b4 = '0; a1 = '0; b1 = '0;
        repeat (3) tick();
        check_val("reset_dut4", {27'd0, busy4, done4, gt4, eq4, lt4}, 32'd0);
        check_val("reset_dut1", {27'd0, busy1, done1, gt1, eq1, lt1}, 32'd0);
        rst = 1'b0;
        tick();

        run4(16'h1234, 16'h1234);
        run4(16'h1000, 16'h0FFF);
        run4(16'h0001, 16'h0002);
        run4(16'h8000, 16'h7FFF);
        run4(16'hFFFF, 16'h0000);
        run4(16'h5A5A, 16'h5A5B);
        run4(16'h4321, 16'h1234);

        // Start while busy is ignored.
        base_cnt = done4_cnt;
        a4 = 16'h0005; b4 = 16'h0003; start4 = 1'b1;
        q4.push_back(exp16(16'h0005, 16'h0003));
        tick();
        start4 = 1'b0;
        tick();
        start4 = 1'b1; a4 = 16'h0000; b4 = 16'hFFFF;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        check_val("busy_ignore_done", {31'd0, done4}, 32'd1);
        repeat (8) tick();
        check_val("busy_ignore_count", done4_cnt - base_cnt, 32'd1);

        // Reset in the middle of RUN aborts without a done pulse.
        base_cnt = done4_cnt;
        a4 = 16'h9999; b4 = 16'h1111; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("abort_outputs", {27'd0, busy4, done4, gt4, eq4, lt4}, 32'd0);
        repeat (8) tick();
        check_val("abort_no_done", done4_cnt - base_cnt, 32'd0);

        // Reset has priority over a simultaneous start.
        rst = 1'b1; start4 = 1'b1;
        tick();
        rst = 1'b0; start4 = 1'b0;
        check_val("rst_wins_busy", {31'd0, busy4}, 32'd0);
        repeat (6) tick();
        check_val("rst_wins_no_done", done4_cnt - base_cnt, 32'd0);

        // Back-to-back compares with start held high.
        e_a = exp16(16'h7000, 16'h0123);
        e_b = exp16(16'h0042, 16'h0042);
        a4 = 16'h7000; b4 = 16'h0123; start4 = 1'b1;
        q4.push_back(e_a);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 5) begin
                check_val("b2b_first_done", {31'd0, done4}, 32'd1);
                a4 = 16'h0042; b4 = 16'h0042;
                q4.push_back(e_b);
            end else if (c == 6) begin
                start4 = 1'b0;
                check_val("b2b_rerun_busy", {31'd0, busy4}, 32'd1);
            end else if (c == 10) begin
                check_val("b2b_second_done", {31'd0, done4}, 32'd1);
            end else begin
                check_val("b2b_no_done", {31'd0, done4}, 32'd0);
            end
        end
        repeat (3) tick();

        // Exhaustive sweep on the single-nibble instance, back to back.
        for (int i = 0; i < 256; i++) begin
            a1 = i[7:4];
            b1 = i[3:0];
            start1 = 1'b1;
            q1.push_back(exp4(a1, b1));
            tick();
            start1 = 1'b0;
            check_val("n1_busy", {30'd0, busy1, done1}, 32'd2);
            tick();
            check_val("n1_done", {30'd0, busy1, done1}, 32'd1);
        end
        repeat (4) tick();

        check_val("dut4_queue_empty", q4.size(), 32'd0);
        check_val("dut1_queue_empty", q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
